// File: rtl/step_pulse_seq.sv
// Stepper step-pulse sequencer: div-clock period timer driving coil phase and position.
// Build with HALF_STEP_EN defined for the 8-entry half-step phase table.
module step_pulse_seq #(
  parameter logic [31:0] DIV_MIN  = 32'd1,
  parameter logic [31:0] POS_INIT = 32'd0
) (
  input  logic        clk,
  input  logic        res,
  input  logic [31:0] div,
  input  logic        run,
  input  logic        dir,
  input  logic        hold,
  output logic [3:0]  phase,
  output logic        step,
  output logic [31:0] pos,
  output logic        busy
);

`ifdef HALF_STEP_EN
  localparam int IW = 3;
`else
  localparam int IW = 2;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  logic [31:0]   cnt;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nx;
  logic [31:0]   d_eff;

  function automatic logic [3:0] pat(input logic [IW-1:0] i);
    logic [3:0] p;
    p = 4'b0000;
`ifdef HALF_STEP_EN
    case (i)
      3'd0: p = 4'b0001;
      3'd1: p = 4'b0011;
      3'd2: p = 4'b0010;
      3'd3: p = 4'b0110;
      3'd4: p = 4'b0100;
      3'd5: p = 4'b1100;
      3'd6: p = 4'b1000;
      3'd7: p = 4'b1001;
      default: p = 4'b0000;
    endcase
`else
    case (i)
      2'd0: p = 4'b0011;
      2'd1: p = 4'b0110;
      2'd2: p = 4'b1100;
      2'd3: p = 4'b1001;
      default: p = 4'b0000;
    endcase
`endif
    return p;
  endfunction

  // Floored period and the neighbouring phase index (power-of-two wrap).
  always_comb begin
    d_eff  = (div < DIV_MIN) ? DIV_MIN : div;
    idx_nx = dir ? idx + 1'b1 : idx - 1'b1;
  end

  // Sequencer FSM: period countdown, step strobe, phase and position.
  always_ff @(posedge clk) begin
    if (res) begin
      state <= IDLE;
      cnt   <= DIV_MIN;
      idx   <= '0;
      step  <= 1'b0;
      pos   <= POS_INIT;
      busy  <= 1'b0;
      phase <= hold ? pat('0) : 4'b0000;
    end else begin
      unique case (state)
        IDLE: begin
          step <= 1'b0;
          if (run) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= d_eff;
            phase <= pat(idx);
          end else begin
            busy  <= 1'b0;
            phase <= hold ? pat(idx) : 4'b0000;
          end
        end
        RUN: begin
          if (!run) begin
            state <= IDLE;
            busy  <= 1'b0;
            step  <= 1'b0;
            phase <= hold ? pat(idx) : 4'b0000;
          end else if (cnt == 32'd1) begin
            step  <= 1'b1;
            idx   <= idx_nx;
            pos   <= dir ? pos + 32'd1 : pos - 32'd1;
            cnt   <= d_eff;
            phase <= pat(idx_nx);
          end else begin
            step  <= 1'b0;
            cnt   <= cnt - 32'd1;
            phase <= pat(idx);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          step  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_pulse_seq.sv
// Testbench for step_pulse_seq: directed table, corner sequences, random vs model.
// Honours HALF_STEP_EN to select the expected phase table.
module tb_step_pulse_seq;

  logic        clk = 1'b0;
  logic        res, run, dir, hold;
  logic [31:0] div;
  logic [3:0]  phase;
  logic        step, busy;
  logic [31:0] pos;

  int checks = 0;
  int errors = 0;

  step_pulse_seq dut (
    .clk(clk), .res(res), .div(div), .run(run), .dir(dir),
    .hold(hold), .phase(phase), .step(step), .pos(pos), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef HALF_STEP_EN
  localparam int NSEQ = 8;
`else
  localparam int NSEQ = 4;
`endif
  logic [3:0] pat_t [8];

  // reference model: motion flag, edges left until the next step
  bit          m_run;
  int          m_left;
  int          m_idx;
  logic [31:0] m_pos;
  logic        m_step;

  function automatic logic [3:0] m_phase(input logic h);
    return (m_run || h) ? pat_t[m_idx] : 4'b0000;
  endfunction

  task automatic model(input logic r, input logic ru, input logic d,
                       input logic [31:0] dv);
    int per;
    per = (dv == 0) ? 1 : int'(dv);
    if (r) begin
      m_run = 0; m_idx = 0; m_pos = 0; m_step = 0; m_left = 0;
    end else if (!m_run) begin
      m_step = 0;
      if (ru) begin m_run = 1; m_left = per; end
    end else if (!ru) begin
      m_run = 0; m_step = 0;
    end else begin
      m_left = m_left - 1;
      m_step = 0;
      if (m_left == 0) begin
        m_step = 1;
        m_left = per;
        m_idx = (m_idx + (d ? 1 : NSEQ - 1)) % NSEQ;
        m_pos = d ? m_pos + 1 : m_pos - 1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick(input logic r, input logic ru, input logic d,
                      input logic h, input logic [31:0] dv);
    res = r; run = ru; dir = d; hold = h; div = dv;
    @(posedge clk);
    model(r, ru, d, dv);
    @(negedge clk);
    chk("m_step", {31'd0, step}, {31'd0, m_step});
    chk("m_busy", {31'd0, busy}, {31'd0, m_run});
    chk("m_pos", pos, m_pos);
    chk("m_phase", {28'd0, phase}, {28'd0, m_phase(h)});
  endtask

  typedef struct {
    logic r, ru, d, h;
    logic [31:0] dv;
    logic s, b;
    logic [31:0] p;
    int ix;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic ru, logic d, logic h,
                              logic [31:0] dv, logic s, logic b,
                              logic [31:0] p, int ix);
    vec_t v;
    v.r = r; v.ru = ru; v.d = d; v.h = h; v.dv = dv;
    v.s = s; v.b = b; v.p = p; v.ix = ix;
    return v;
  endfunction

  initial begin
    logic [3:0] ep;
`ifdef HALF_STEP_EN
    pat_t = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
              4'b0100, 4'b1100, 4'b1000, 4'b1001};
`else
    pat_t = '{4'b0011, 4'b0110, 4'b1100, 4'b1001,
              4'b0000, 4'b0000, 4'b0000, 4'b0000};
`endif
    res = 1; run = 0; dir = 0; hold = 0; div = 0;
    m_run = 0; m_idx = 0; m_pos = 0; m_step = 0; m_left = 0;

    // r ru d h div | step busy pos idx(-1 = off)
    tbl.push_back(mk(1, 0, 1, 1, 4, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 4, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 4, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 4, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 4, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 4, 1, 1, 1, 1));
    tbl.push_back(mk(0, 1, 1, 1, 4, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 1, 1, 4, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 1, 1, 4, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 1, 1, 4, 1, 1, 2, 2));
    tbl.push_back(mk(0, 1, 1, 1, 4, 0, 1, 2, 2));
    tbl.push_back(mk(0, 1, 1, 1, 4, 0, 1, 2, 2));
    tbl.push_back(mk(0, 1, 1, 1, 4, 0, 1, 2, 2));
    tbl.push_back(mk(0, 1, 1, 1, 4, 1, 1, 3, 3));
    tbl.push_back(mk(0, 1, 1, 1, 4, 0, 1, 3, 3));
    tbl.push_back(mk(0, 1, 1, 1, 4, 0, 1, 3, 3));
    tbl.push_back(mk(0, 1, 1, 1, 4, 0, 1, 3, 3));
    tbl.push_back(mk(0, 1, 1, 1, 4, 1, 1, 4, 4 % NSEQ));
    tbl.push_back(mk(0, 1, 1, 1, 4, 0, 1, 4, 4 % NSEQ));
    tbl.push_back(mk(0, 1, 1, 1, 4, 0, 1, 4, 4 % NSEQ));
    tbl.push_back(mk(0, 1, 1, 1, 4, 0, 1, 4, 4 % NSEQ));
    tbl.push_back(mk(0, 1, 1, 1, 4, 1, 1, 5, 5 % NSEQ));
    tbl.push_back(mk(0, 0, 1, 0, 4, 0, 0, 5, -1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 1, 1, 32'hFFFF_FFFF, NSEQ - 1));
    tbl.push_back(mk(0, 1, 0, 1, 0, 1, 1, 32'hFFFF_FFFE, NSEQ - 2));

    @(negedge clk);
    foreach (tbl[i]) begin
      tick(tbl[i].r, tbl[i].ru, tbl[i].d, tbl[i].h, tbl[i].dv);
      ep = (tbl[i].ix < 0) ? 4'b0000 : pat_t[tbl[i].ix];
      chk($sformatf("t%0d_step", i), {31'd0, step}, {31'd0, tbl[i].s});
      chk($sformatf("t%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].b});
      chk($sformatf("t%0d_pos", i), pos, tbl[i].p);
      chk($sformatf("t%0d_phase", i), {28'd0, phase}, {28'd0, ep});
    end

    // div 10 -> 3 while the count is at 6: step at edge 10, then 13, 16
    tick(1, 0, 1, 1, 10);
    tick(0, 1, 1, 1, 10);
    for (int k = 1; k <= 4; k++) tick(0, 1, 1, 1, 10);
    for (int k = 5; k <= 16; k++) begin
      tick(0, 1, 1, 1, 3);
      chk($sformatf("divchg_e%0d", k), {31'd0, step},
          {31'd0, (k == 10 || k == 13 || k == 16)});
    end

    // stop on the edge where the count would have expired
    tick(1, 0, 1, 0, 3);
    tick(0, 1, 1, 0, 3);
    tick(0, 1, 1, 0, 3);
    tick(0, 1, 1, 0, 3);
    tick(0, 0, 1, 0, 3);
    chk("stop_step", {31'd0, step}, 32'd0);
    chk("stop_busy", {31'd0, busy}, 32'd0);
    chk("stop_pos", pos, 32'd0);
    chk("stop_phase", {28'd0, phase}, 32'd0);
    tick(0, 1, 1, 0, 1);
    chk("resume_phase", {28'd0, phase}, {28'd0, pat_t[0]});
    tick(0, 1, 1, 0, 1);
    chk("resume_step", {31'd0, step}, 32'd1);
    chk("resume_phase2", {28'd0, phase}, {28'd0, pat_t[1]});

    // reset mid-period at pos 7
    tick(1, 0, 1, 1, 2);
    tick(0, 1, 1, 1, 2);
    for (int k = 1; k <= 14; k++) tick(0, 1, 1, 1, 2);
    chk("rst_pre_pos", pos, 32'd7);
    tick(0, 1, 1, 1, 2);
    tick(1, 1, 1, 1, 2);
    chk("rst_pos", pos, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_step", {31'd0, step}, 32'd0);
    tick(0, 0, 1, 1, 2);
    chk("rst_nostep", {31'd0, step}, 32'd0);
    chk("rst_pos2", pos, 32'd0);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      tick(($urandom_range(63) == 0), ($urandom_range(7) != 0),
           1'($urandom_range(1)), 1'($urandom_range(1)),
           32'($urandom_range(6)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_pulse_seq.md
Name: step_pulse_seq

Overview:
- Consumes the 32-bit division count from the speed-control block and generates stepper-motor step timing.
- Each elapsed period of `div` clocks produces one step: a one-cycle `step` strobe, the coil phase pattern advancing one position, and a signed position counter updating.
- Sits between the speed controller and the coil driver outputs.

Parameters:
- DIV_MIN, 32'd1, floor applied to `div`; any smaller value (including 0) is treated as DIV_MIN. Must be >= 1.
- POS_INIT, 32'd0, reset value of `pos`.

Ports:
- clk  input  1  system clock
- res  input  1  synchronous reset, active-high
- div  input  32  step period in clk cycles, from speed controller
- run  input  1  1 = generate steps, 0 = stop
- dir  input  1  1 = forward (phase index +1, pos +1), 0 = reverse
- hold  input  1  when stopped: 1 = keep current phase energised, 0 = drive `phase` 4'b0000
- phase  output  4  coil drive pattern {B-, A-, B+, A+}
- step  output  1  one-cycle strobe per step
- pos  output  32  signed step position, two's complement
- busy  output  1  1 while in RUN state

Behaviour:
- Reset (`res` = 1 at a clk edge): state = IDLE, counter `cnt` = DIV_MIN, phase index = 0, `step` = 0, `pos` = POS_INIT, `busy` = 0.
  - `phase` after reset = 4'b0000 if `hold` = 0, else the index-0 pattern.
  - Reset overrides everything, including mid-period; no step is issued on the reset edge.
- Effective period D = (div < DIV_MIN) ? DIV_MIN : div. Compare is unsigned.
- State IDLE:
  - `busy` = 0, `step` = 0.
  - On an edge with `run` = 1: go to RUN, load `cnt` <= D (`div` sampled on that edge).
- State RUN:
  - `busy` = 1.
  - Edge with `run` = 0: go to IDLE, `step` <= 0, no phase/pos change, even if `cnt` == 1 (stop wins).
  - Edge with `run` = 1 and `cnt` == 1:
    - `step` <= 1.
    - Phase index advances ±1 per `dir` sampled on that edge, wrapping modulo sequence length.
    - `pos` <= pos ± 1, 32-bit wrap; no saturation.
    - `cnt` <= D, with `div` sampled on that edge.
  - Edge with `run` = 1 and `cnt` != 1: `cnt` <= cnt − 1, `step` <= 0.
- Latency and period:
  - First `step` is high in the cycle after the D-th edge following the edge that sampled `run` = 1.
  - Subsequent steps are exactly D cycles apart.
  - D = 1 gives `step` high every cycle.
- A change on `div` mid-period does not affect the running count; it takes effect at the next reload. No glitch, no early step.
- A `dir` change mid-period takes effect at the next step only.
- `phase` is registered, derived from the phase index.
  - In IDLE with `hold` = 0, `phase` = 4'b0000, but the index is retained.
  - On restart, motion resumes from the retained index.
- `step`, `phase` and `pos` update on the same edge; they are never skewed.

Optional Feature:
- Macro HALF_STEP_EN.
- Defined: 8-state half-step sequence, index 0..7:
  - 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001.
- Undefined: 4-state two-phase full-step sequence, index 0..3:
  - 0011, 0110, 1100, 1001.
- `pos` counts sequence entries in both modes; port list is unchanged.

Test Plan:
- Reset, `hold` = 1, `run` = 0 -> `phase` = 0011 (full-step) / 0001 (half-step), `pos` = 0, `step` = 0, `busy` = 0.
- `div` = 4, `dir` = 1, `run` raised and held 20 cycles -> first `step` 4 edges after the run-sampling edge, then every 4 cycles (5 steps).
  - Full-step: `phase` 0110, 1100, 1001, 0011, 0110; `pos` = 5.
- `div` = 0, `run` = 1 -> `step` every cycle (DIV_MIN = 1).
  - `dir` = 0 from `pos` = 0 -> `pos` = 0xFFFFFFFF after first step; full-step `phase` goes 0011 -> 1001.
- `div` = 10; change `div` to 3 at `cnt` = 6 -> current step still lands 10 cycles after the previous one, then steps are 3 cycles apart.
- `run` dropped on the edge where `cnt` == 1 -> no `step`, `pos` unchanged, `busy` = 0.
  - With `hold` = 0, `phase` = 0000; re-raising `run` resumes from the retained pattern.
- Assert `res` mid-period at `pos` = 7 -> next cycle `pos` = 0, `busy` = 0, `step` = 0; the pending step is never issued.
